// File: rtl/pixel_fetch.sv
// Pixel fetcher: reads four consecutive bytes from a byte buffer and hands
// them out as one RGBA pixel with a valid/ready handshake, one frame per start.
module pixel_fetch #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       pixel,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              pixel_last,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // ISSUE | four read strobes at base+0..base+3
  // DRAIN | last byte (A) arriving, pixel completes
  // OUT   | pixel presented, waiting for transfer
  // DONE  | frame finished, waiting for start
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t      r_state;
  addr_t       r_base;
  logic [1:0]  r_cnt;
  addr_t       r_mem_addr;
  logic        r_mem_cs;
  logic        r_rd_pend;
  logic [1:0]  r_rd_lane;
  logic [31:0] r_pixel;
  logic        r_valid;
  logic        r_last;
  logic        r_busy;
  logic        r_done;

  // base is always a multiple of 4, so OR-ing the low bits finds the last pixel
  logic w_base_is_last;
  assign w_base_is_last = &(r_base | addr_t'(3));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_mem_cs   <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_lane  <= '0;
      r_pixel    <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_pend <= r_mem_cs;
      r_rd_lane <= r_cnt;
      if (r_rd_pend) begin
        case (r_rd_lane)
          2'd0:    r_pixel[31:24] <= mem_rdata;
          2'd1:    r_pixel[23:16] <= mem_rdata;
          2'd2:    r_pixel[15:8]  <= mem_rdata;
          default: r_pixel[7:0]   <= mem_rdata;
        endcase
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_ISSUE;
            r_base     <= '0;
            r_cnt      <= '0;
            r_mem_addr <= '0;
            r_mem_cs   <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (r_cnt == 2'd3) begin
            r_state  <= S_DRAIN;
            r_mem_cs <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + 2'd1;
            r_mem_addr <= r_base + addr_t'(r_cnt) + addr_t'(1);
            r_mem_cs   <= 1'b1;
          end
        end
        S_DRAIN: begin
          r_state <= S_OUT;
          r_valid <= 1'b1;
          r_last  <= w_base_is_last;
        end
        S_OUT: begin
          if (pixel_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (r_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_ISSUE;
              r_base     <= r_base + addr_t'(4);
              r_cnt      <= '0;
              r_mem_addr <= r_base + addr_t'(4);
              r_mem_cs   <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_cs      = r_mem_cs;
  assign mem_we      = 1'b0;
  assign mem_wdata   = 8'h00;
  assign pixel       = r_pixel;
  assign pixel_valid = r_valid;
  assign pixel_last  = r_last;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
